// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO input conditioner: channel count,
// channel index map {sw[7:0], btnc, btnr, btnd, btnl, btnu} and default timing.
package gpio_pkg;

    localparam int unsigned GPIO_N_IN = 13;

    localparam int unsigned GPIO_BTNU = 0;
    localparam int unsigned GPIO_BTNL = 1;
    localparam int unsigned GPIO_BTND = 2;
    localparam int unsigned GPIO_BTNR = 3;
    localparam int unsigned GPIO_BTNC = 4;
    localparam int unsigned GPIO_SW0  = 5;
    localparam int unsigned GPIO_SW1  = 6;
    localparam int unsigned GPIO_SW2  = 7;
    localparam int unsigned GPIO_SW3  = 8;
    localparam int unsigned GPIO_SW4  = 9;
    localparam int unsigned GPIO_SW5  = 10;
    localparam int unsigned GPIO_SW6  = 11;
    localparam int unsigned GPIO_SW7  = 12;

    // 2.5 ms and 2 s at 100 MHz
    localparam int unsigned GPIO_DEBOUNCE_CYCLES = 250000;
    localparam int unsigned GPIO_LONG_CYCLES     = 200000000;

endpackage

// File: rtl/gpio_debounce_chan.sv
// One GPIO channel: 2-flop synchroniser, counter debounce, registered level
// and one-cycle rise/fall pulses. Long-press hold counter is built only when
// GPIO_INPUT_CONDITIONER_LONGPRESS_EN is defined; otherwise long_pulse is 0.
module gpio_debounce_chan
    import gpio_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = GPIO_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = GPIO_LONG_CYCLES
) (
    input  logic clk,
    input  logic rstn,
    input  logic raw_in,
    output logic level_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic long_pulse
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync_meta_q;
    logic             sync_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    // Two-stage synchroniser for the asynchronous pin
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_meta_q <= 1'b0;
            sync_q      <= 1'b0;
        end else begin
            sync_meta_q <= raw_in;
            sync_q      <= sync_meta_q;
        end
    end

    // Debounce: count consecutive cycles of disagreement, accept on the last one
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level_d = sync_q;
            cnt_d   = '0;
            rise_d  = sync_q;
            fall_d  = ~sync_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Debounce state and edge-pulse registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            level_q <= 1'b0;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_out  = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

`ifdef GPIO_INPUT_CONDITIONER_LONGPRESS_EN
    localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              long_q, long_d;

    // Hold counter follows the next level so the rise cycle counts as 1; saturates
    always_comb begin
        hold_d = '0;
        long_d = 1'b0;
        if (level_d) begin
            if (hold_q != HOLD_W'(LONG_CYCLES)) begin
                hold_d = hold_q + HOLD_W'(1);
            end else begin
                hold_d = hold_q;
            end
            long_d = (hold_q == HOLD_W'(LONG_CYCLES - 1));
        end
    end

    // Hold counter and long-press pulse registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign long_pulse = long_q;
`else
    assign long_pulse = 1'b0;
`endif

endmodule

// File: rtl/gpio_input_conditioner.sv
// Board-level GPIO input conditioner: N_IN independent debounce channels
// between the pins and rtl_top. Optional long-press events are enabled by
// defining GPIO_INPUT_CONDITIONER_LONGPRESS_EN.
module gpio_input_conditioner
    import gpio_pkg::*;
#(
    parameter int unsigned N_IN            = GPIO_N_IN,
    parameter int unsigned DEBOUNCE_CYCLES = GPIO_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = GPIO_LONG_CYCLES
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [N_IN-1:0] raw_in,
    output logic [N_IN-1:0] level_out,
    output logic [N_IN-1:0] rise_pulse,
    output logic [N_IN-1:0] fall_pulse,
    output logic [N_IN-1:0] long_pulse
);

    for (genvar i = 0; i < N_IN; i++) begin : g_chan
        gpio_debounce_chan #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .LONG_CYCLES    (LONG_CYCLES)
        ) u_chan (
            .clk       (clk),
            .rstn      (rstn),
            .raw_in    (raw_in[i]),
            .level_out (level_out[i]),
            .rise_pulse(rise_pulse[i]),
            .fall_pulse(fall_pulse[i]),
            .long_pulse(long_pulse[i])
        );
    end

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Randomised + directed bench for gpio_input_conditioner against a
// window-based reference model of the debounce rules.
module tb_gpio_input_conditioner;

    localparam int unsigned N    = 13;
    localparam int unsigned DEB  = 4;
    localparam int unsigned LONG = 10;
    localparam int HSZ = 4096;

    logic         clk = 1'b0;
    logic         rstn;
    logic [N-1:0] raw_in;
    logic [N-1:0] level_out, rise_pulse, fall_pulse, long_pulse;

    gpio_input_conditioner #(
        .N_IN           (N),
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES    (LONG)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .raw_in    (raw_in),
        .level_out (level_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .long_pulse(long_pulse)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int           ek;
    logic [N-1:0] hist [HSZ];
    logic [N-1:0] d1, d2;
    logic [N-1:0] exp_lvl, exp_rise, exp_fall, exp_long;
    int           last_chg [N];
    int           rise_edge [N];
    int           rise_seen [N];
    int           fall_seen [N];
    int           long_seen [N];
    logic [N-1:0] cur;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        d1 = '0;
        d2 = '0;
        exp_lvl  = '0;
        exp_rise = '0;
        exp_fall = '0;
        exp_long = '0;
        for (int c = 0; c < int'(N); c++) begin
            last_chg[c]  = ek;
            rise_edge[c] = ek;
        end
    endtask

    // A new level is accepted when the synchronised input has disagreed with
    // the current level on each of the last DEB edges since the last change.
    task automatic model_edge(input logic [N-1:0] raw);
        logic [N-1:0] s;
        bit ok;
        ek++;
        s  = d2;
        d2 = d1;
        d1 = raw;
        hist[ek % HSZ] = s;
        exp_rise = '0;
        exp_fall = '0;
        exp_long = '0;
        for (int c = 0; c < int'(N); c++) begin
            if (ek - last_chg[c] >= int'(DEB)) begin
                ok = 1'b1;
                for (int j = 0; j < int'(DEB); j++)
                    if (hist[(ek - j) % HSZ][c] == exp_lvl[c]) ok = 1'b0;
                if (ok) begin
                    exp_lvl[c]  = ~exp_lvl[c];
                    last_chg[c] = ek;
                    if (exp_lvl[c]) begin
                        exp_rise[c]  = 1'b1;
                        rise_edge[c] = ek;
                    end else begin
                        exp_fall[c] = 1'b1;
                    end
                end
            end
`ifdef GPIO_INPUT_CONDITIONER_LONGPRESS_EN
            if (exp_lvl[c] && (ek - rise_edge[c] + 1 == int'(LONG))) exp_long[c] = 1'b1;
`endif
        end
    endtask

    task automatic step(input logic [N-1:0] v);
        raw_in = v;
        @(posedge clk);
        model_edge(v);
        #1;
        check_eq("level", 32'(level_out), 32'(exp_lvl));
        check_eq("rise", 32'(rise_pulse), 32'(exp_rise));
        check_eq("fall", 32'(fall_pulse), 32'(exp_fall));
        check_eq("long", 32'(long_pulse), 32'(exp_long));
        for (int c = 0; c < int'(N); c++) begin
            if (rise_pulse[c]) rise_seen[c]++;
            if (fall_pulse[c]) fall_seen[c]++;
            if (long_pulse[c]) long_seen[c]++;
        end
    endtask

    task automatic clear_seen();
        for (int c = 0; c < int'(N); c++) begin
            rise_seen[c] = 0;
            fall_seen[c] = 0;
            long_seen[c] = 0;
        end
    endtask

    task automatic do_reset();
        #2;
        rstn = 1'b0;
        #1;
        check_eq("rst_level", 32'(level_out), 32'd0);
        check_eq("rst_rise", 32'(rise_pulse), 32'd0);
        check_eq("rst_fall", 32'(fall_pulse), 32'd0);
        check_eq("rst_long", 32'(long_pulse), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rstn = 1'b1;
        model_reset();
    endtask

    // Edges from the first sampling edge until level_out[ch] is seen high
    task automatic measure(input int ch, output int n);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            step(cur);
            n++;
            if (level_out[ch]) break;
        end
        if (!level_out[ch]) n = 99;
    endtask

    initial begin
        int lat;
        ek     = 0;
        cur    = '0;
        raw_in = '0;
        rstn   = 1'b0;
        model_reset();
        clear_seen();
        repeat (2) @(posedge clk);
        #2;
        check_eq("init_level", 32'(level_out), 32'd0);
        check_eq("init_pulses", 32'(rise_pulse | fall_pulse | long_pulse), 32'd0);
        rstn = 1'b1;
        model_reset();

        // Idle with all inputs low
        repeat (20) step(cur);

        // Clean step on btnu
        cur[0] = 1'b1;
        measure(0, lat);
        check_eq("lat_ch0", 32'(lat), 32'(DEB + 2));
        check_eq("lat_ch0_others", 32'(level_out[N-1:1]), 32'd0);
        repeat (3) step(cur);

        // Glitch rejection then exact-length acceptance on btnr
        clear_seen();
        cur[3] = 1'b1;
        repeat (3) step(cur);
        cur[3] = 1'b0;
        repeat (10) step(cur);
        check_eq("glitch3_rej", 32'(rise_seen[3]), 32'd0);
        cur[3] = 1'b1;
        repeat (DEB) step(cur);
        cur[3] = 1'b0;
        repeat (14) step(cur);
        check_eq("accept3_rise", 32'(rise_seen[3]), 32'd1);
        check_eq("accept3_fall", 32'(fall_seen[3]), 32'd1);

        // Simultaneous switch changes
        cur[12:5] = 8'hA5;
        repeat (8) step(cur);
        check_eq("sw_a5", 32'(level_out[12:5]), 32'hA5);

        // Reset in the middle of a channel-1 debounce
        cur[1] = 1'b1;
        repeat (4) step(cur);
        do_reset();
        clear_seen();
        measure(1, lat);
        check_eq("lat_ch1_after_rst", 32'(lat), 32'(DEB + 2));
        check_eq("ch1_single_rise", 32'(rise_seen[1]), 32'd1);

        // Long hold on btnc
        clear_seen();
        cur[4] = 1'b1;
        measure(4, lat);
        repeat (30) step(cur);
`ifdef GPIO_INPUT_CONDITIONER_LONGPRESS_EN
        check_eq("long_btnc", 32'(long_seen[4]), 32'd1);
`else
        check_eq("long_btnc", 32'(long_seen[4]), 32'd0);
`endif
        cur[4] = 1'b0;
        repeat (10) step(cur);

        // Random toggling with mixed run lengths, one reset in the middle
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < int'(N); c++)
                if ($urandom_range(0, 7) == 0) cur[c] = ~cur[c];
            if (i == 700) do_reset();
            step(cur);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gpio_input_conditioner.md
Name: gpio_input_conditioner

Overview:
- Conditions the board's raw asynchronous GPIO inputs (5 push-buttons, 8 slide switches) before they reach rtl_top and the LED logic.
- Per channel: 2-flop synchroniser, counter-based debounce, registered level output and one-cycle rise/fall event pulses.
- Instantiated in the board top between the pins and rtl_top.

Parameters:
- N_IN, 13, number of channels; packed as {sw[7:0], btnc, btnr, btnd, btnl, btnu}.
- DEBOUNCE_CYCLES, 250000, consecutive stable synchronised cycles needed to accept a new level (2.5 ms at 100 MHz); legal range >= 1.
- LONG_CYCLES, 200000000, cycles level must stay high for a long-press event; used only with the optional feature.

Ports:
- clk  input  1  system clock.
- rstn  input  1  asynchronous active-low reset.
- raw_in  input  N_IN  unsynchronised pin levels.
- level_out  output  N_IN  debounced level.
- rise_pulse  output  N_IN  one-cycle pulse when level_out goes 0->1.
- fall_pulse  output  N_IN  one-cycle pulse when level_out goes 1->0.
- long_pulse  output  N_IN  one-cycle long-press event.

Behaviour:
- Reset (rstn low, asynchronous assert) clears all state to 0:
  - sync flops, stable level, counters;
  - level_out, rise_pulse, fall_pulse and long_pulse all 0.
- Synchroniser: sync_q = raw_in delayed by 2 flops.
- Counter width is CNT_W = $clog2(DEBOUNCE_CYCLES+1).
- Per channel, on each clk edge:
  - If sync_q == level_out: cnt <= 0, no event.
  - Else if cnt == DEBOUNCE_CYCLES-1: level_out <= sync_q, cnt <= 0, and the matching rise_pulse or fall_pulse is asserted for exactly that one following cycle.
  - Else: cnt <= cnt + 1.
- Pulse timing: rise_pulse/fall_pulse are high in the same cycle in which the new level_out first appears. They deassert the next cycle.
- Latency: a clean raw_in step is reflected on level_out DEBOUNCE_CYCLES+2 edges after the first edge that samples it.
- Glitch rule:
  - A sync_q deviation lasting DEBOUNCE_CYCLES-1 cycles or fewer is rejected; cnt clears on return.
  - A deviation lasting exactly DEBOUNCE_CYCLES cycles is accepted.
- DEBOUNCE_CYCLES = 1: level follows sync_q with 1 cycle of registration.
- Channels are fully independent; simultaneous changes on any subset produce simultaneous, independent pulses.
- Reset release with raw_in high: after DEBOUNCE_CYCLES+2 edges, level_out goes 1 with rise_pulse. This is intended, so switches are reported as events at startup.
- Reset mid-debounce: cnt is discarded, no pulse is emitted, and the state is treated as fresh.
- The counter never overflows, because it is cleared on acceptance or on a match.
- rise_pulse and fall_pulse are never both high on one channel.

Optional Feature:
- Macro: GPIO_INPUT_CONDITIONER_LONGPRESS_EN.
- Defined:
  - Per-channel hold counter (width $clog2(LONG_CYCLES+1)) cleared while level_out == 0; the cycle carrying rise_pulse counts as 1.
  - long_pulse is asserted for one cycle on the LONG_CYCLES-th consecutive high cycle. The counter then saturates, so only one event per press.
  - A fall, or reset, rearms the channel.
- Undefined: no hold counters are generated; long_pulse is tied to 0; the LONG_CYCLES parameter is ignored.

Decomposition:
- Package gpio_pkg holds:
  - GPIO_N_IN = 13;
  - channel index constants (GPIO_BTNU=0 ... GPIO_BTNC=4, GPIO_SW0=5 ... GPIO_SW7=12);
  - default DEBOUNCE_CYCLES and LONG_CYCLES constants.
- Sub-module gpio_debounce_chan: one channel (sync, debounce counter, edge pulses, optional hold counter).
- The top instantiates N_IN copies with a generate loop.

Test Plan (bench uses DEBOUNCE_CYCLES=4, LONG_CYCLES=10):
- Reset then raw_in=0 for 20 cycles -> all outputs 0 throughout; no pulses.
- raw_in[0] 0->1 held -> level_out[0]=1 with rise_pulse[0] high one cycle, exactly 6 edges after the sampling edge; other channels stay 0.
- raw_in[3] glitch high for 3 synchronised cycles -> no change on level_out[3]. Then high for exactly 4 cycles -> accepted, rise then (after release + 6 edges) fall_pulse[3].
- raw_in[12:5]=8'hA5 applied simultaneously -> the four set channels rise together on the same cycle; level_out[12:5]=8'hA5.
- rstn asserted mid-count (cnt=2) on channel 1 -> no pulse; after release a fresh full 6-edge latency is observed.
- With GPIO_INPUT_CONDITIONER_LONGPRESS_EN, hold btnc 30 cycles after acceptance -> single long_pulse[4] on the 10th high cycle (rise cycle = 1). Without the macro -> long_pulse stays 0.
